dma_copy: RTL and testbench

- Word-copy DMA engine; a second initiator on the common memory bus, alongside the rv32 core.
- Configured by the CPU as an ordinary memory-mapped responder (proposed decode 0x00040000–0x0004000F).
- Once started, it reads words from SRC and writes them to DST, LEN times, then sets a sticky done flag.
- Arbitration between the core and this engine is handled by a bus arbiter extension, which is outside this block.

---
 rtl/dma_pkg.sv | 29 ++
 rtl/dma_copy.sv | 162 ++++++++++++++++
 tb/tb_dma_copy.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and register map for the dma_copy word-copy engine
package dma_pkg;

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_FAULT = 2;

  // Byte-lane merge used by every config register write.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_value,
                                              input logic [31:0] new_value,
                                              input logic [3:0]  mask);
    logic [31:0] result;
    for (int i = 0; i < 4; i++) begin
      result[i*8 +: 8] = mask[i] ? new_value[i*8 +: 8] : old_value[i*8 +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/dma_copy.sv
// rtl/dma_copy.sv - word-copy DMA engine: config responder plus RD/WR initiator FSM
module dma_copy
  import dma_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  output logic [31:0] read_value_out,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic        ready_out,
  output logic [31:0] m_address_out,
  output logic        m_read_out,
  output logic        m_write_out,
  input  logic [31:0] m_read_value_in,
  output logic [3:0]  m_write_mask_out,
  output logic [31:0] m_write_value_out,
  input  logic        m_ready_in,
  input  logic        m_fault_in
);

  state_t               state;
  logic [31:0]          src;
  logic [31:0]          dst;
  logic [LEN_WIDTH-1:0] len;
  logic                 done;
  logic                 fault;
  logic                 abort_req;

  logic [1:0]  reg_sel;
  logic        cfg_write;
  logic        busy;
  logic        start_write;
  logic        abort_write;
  logic [31:0] len_zx;
  logic [31:0] src_merged;
  logic [31:0] dst_merged;
  logic [31:0] len_merged;
  logic        unused_ok;

  assign reg_sel     = address_in[3:2];
  assign cfg_write   = sel_in && (write_mask_in != 4'b0000);
  assign busy        = (state != IDLE);
  assign start_write = cfg_write && (reg_sel == REG_CTRL) && write_mask_in[0]
                       && write_value_in[CTRL_START];
  assign abort_write = cfg_write && (reg_sel == REG_CTRL) && write_mask_in[0]
                       && write_value_in[CTRL_ABORT];
  assign len_zx      = {{(32-LEN_WIDTH){1'b0}}, len};
  assign src_merged  = merge_bytes(src, write_value_in, write_mask_in);
  assign dst_merged  = merge_bytes(dst, write_value_in, write_mask_in);
  assign len_merged  = merge_bytes(len_zx, write_value_in, write_mask_in);
  assign ready_out   = sel_in;
  assign unused_ok   = ^{address_in[31:4], address_in[1:0], len_merged};

  always_comb begin
    read_value_out = 32'd0;
    if (sel_in && read_in) begin
      case (reg_sel)
        REG_SRC:  read_value_out = src;
        REG_DST:  read_value_out = dst;
        REG_LEN:  read_value_out = len_zx;
        default: begin
          read_value_out[STAT_BUSY]  = busy;
          read_value_out[STAT_DONE]  = done;
          read_value_out[STAT_FAULT] = fault;
        end
      endcase
    end
  end

  // Bus request outputs are registered with the state so they only change at
  // a transaction boundary and hold steady through responder wait cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      src               <= 32'd0;
      dst               <= 32'd0;
      len               <= '0;
      done              <= 1'b0;
      fault             <= 1'b0;
      abort_req         <= 1'b0;
      m_address_out     <= 32'd0;
      m_read_out        <= 1'b0;
      m_write_out       <= 1'b0;
      m_write_mask_out  <= 4'b0000;
      m_write_value_out <= 32'd0;
    end else begin
      if (busy && abort_write) begin
        abort_req <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (cfg_write && reg_sel == REG_SRC) src <= {src_merged[31:2], 2'b00};
          if (cfg_write && reg_sel == REG_DST) dst <= {dst_merged[31:2], 2'b00};
          if (cfg_write && reg_sel == REG_LEN) len <= len_merged[LEN_WIDTH-1:0];
          if (start_write) begin
            if (len != '0) begin
              done          <= 1'b0;
              fault         <= 1'b0;
              abort_req     <= 1'b0;
              state         <= RD;
              m_read_out    <= 1'b1;
              m_address_out <= src;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RD: begin
          if (m_fault_in) begin
            fault         <= 1'b1;
            state         <= IDLE;
            m_read_out    <= 1'b0;
            m_address_out <= 32'd0;
          end else if (m_ready_in) begin
            state             <= WR;
            m_read_out        <= 1'b0;
            m_write_out       <= 1'b1;
            m_address_out     <= dst;
            m_write_value_out <= m_read_value_in;
            m_write_mask_out  <= 4'b1111;
          end
        end
        WR: begin
          if (m_fault_in) begin
            fault             <= 1'b1;
            state             <= IDLE;
            m_write_out       <= 1'b0;
            m_address_out     <= 32'd0;
            m_write_mask_out  <= 4'b0000;
            m_write_value_out <= 32'd0;
          end else if (m_ready_in) begin
            src               <= src + 32'd4;
            dst               <= dst + 32'd4;
            len               <= len - LEN_WIDTH'(1);
            m_write_out       <= 1'b0;
            m_write_mask_out  <= 4'b0000;
            m_write_value_out <= 32'd0;
            if (len == LEN_WIDTH'(1)) begin
              done          <= 1'b1;
              state         <= IDLE;
              m_address_out <= 32'd0;
            end else if (abort_req || abort_write) begin
              state         <= IDLE;
              m_address_out <= 32'd0;
            end else begin
              state         <= RD;
              m_read_out    <= 1'b1;
              m_address_out <= src + 32'd4;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_copy.sv
// tb/tb_dma_copy.sv - directed self-checking bench for dma_copy
module tb_dma_copy;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address_in;
  logic        sel_in;
  logic        read_in;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic        ready_out;
  logic [31:0] m_address_out;
  logic        m_read_out;
  logic        m_write_out;
  logic [31:0] m_read_value_in;
  logic [3:0]  m_write_mask_out;
  logic [31:0] m_write_value_out;
  logic        m_ready_in;
  logic        m_fault_in;

  always #5 clk = ~clk;

  dma_copy #(.LEN_WIDTH(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .address_in        (address_in),
    .sel_in            (sel_in),
    .read_in           (read_in),
    .read_value_out    (read_value_out),
    .write_mask_in     (write_mask_in),
    .write_value_in    (write_value_in),
    .ready_out         (ready_out),
    .m_address_out     (m_address_out),
    .m_read_out        (m_read_out),
    .m_write_out       (m_write_out),
    .m_read_value_in   (m_read_value_in),
    .m_write_mask_out  (m_write_mask_out),
    .m_write_value_out (m_write_value_out),
    .m_ready_in        (m_ready_in),
    .m_fault_in        (m_fault_in)
  );

  // Responder model: fixed wait count, fixed read contents, optional read fault.
  int          waits = 0;
  int          cnt = 0;
  logic        fault_en = 1'b0;
  logic [31:0] fault_addr = 32'd0;
  logic        req;

  assign req        = m_read_out | m_write_out;
  assign m_ready_in = req && (cnt == waits);
  assign m_fault_in = fault_en && m_read_out && m_ready_in && (m_address_out == fault_addr);

  always_comb begin
    case (m_address_out)
      32'h100: m_read_value_in = 32'hA;
      32'h104: m_read_value_in = 32'hB;
      32'h108: m_read_value_in = 32'hC;
      32'h10C: m_read_value_in = 32'hD;
      32'h110: m_read_value_in = 32'hE;
      default: m_read_value_in = 32'hDEAD_BEEF;
    endcase
  end

  always @(posedge clk) begin
    if (req && !m_ready_in) cnt <= cnt + 1;
    else                    cnt <= 0;
  end

  int          wr_count = 0;
  logic [31:0] wlog_addr [64];
  logic [31:0] wlog_data [64];

  always @(posedge clk) begin
    if (m_write_out && m_ready_in && !m_fault_in && wr_count < 64) begin
      wlog_addr[wr_count] = m_address_out;
      wlog_data[wr_count] = m_write_value_out;
      wr_count++;
    end
  end

  int       stab_err = 0;
  int       wait_cycles = 0;
  int       req_cycles = 0;
  logic     pend = 1'b0;
  logic [69:0] prev_req = '0;

  always @(negedge clk) begin
    if (pend && ({m_read_out, m_write_out, m_address_out, m_write_mask_out, m_write_value_out} != prev_req))
      stab_err++;
    if (req) req_cycles++;
    if (req && !m_ready_in) wait_cycles++;
    pend     = req && !m_ready_in;
    prev_req = {m_read_out, m_write_out, m_address_out, m_write_mask_out, m_write_value_out};
  end

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [3:0] off, input logic [31:0] data, input logic [3:0] mask);
    address_in     = 32'h0004_0000 | {28'd0, off};
    sel_in         = 1'b1;
    read_in        = 1'b0;
    write_mask_in  = mask;
    write_value_in = data;
    @(posedge clk);
    #1;
    sel_in         = 1'b0;
    write_mask_in  = 4'b0000;
    write_value_in = 32'd0;
  endtask

  task automatic cfg_read(input logic [3:0] off, output logic [31:0] value);
    address_in    = 32'h0004_0000 | {28'd0, off};
    sel_in        = 1'b1;
    read_in       = 1'b1;
    write_mask_in = 4'b0000;
    #1;
    value   = read_value_out;
    sel_in  = 1'b0;
    read_in = 1'b0;
  endtask

  task automatic wait_not_busy(output int cycles);
    logic [31:0] s;
    cycles = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      cycles++;
      cfg_read(4'hC, s);
      if (!s[0]) break;
    end
  endtask

  task automatic setup(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
    cfg_write(4'h0, s, 4'hF);
    cfg_write(4'h4, d, 4'hF);
    cfg_write(4'h8, l, 4'hF);
  endtask

  initial begin
    logic [31:0] v;
    int          cycles;
    int          base;
    int          base_wait;
    int          base_stab;
    int          base_req;

    reset = 1'b1;
    address_in = 32'd0; sel_in = 1'b0; read_in = 1'b0;
    write_mask_in = 4'b0000; write_value_in = 32'd0;
    @(posedge clk); #1;
    check("reset_m_outs", 32'(|{m_read_out, m_write_out, m_address_out, m_write_mask_out, m_write_value_out}), 32'd0);
    check("reset_rdata_unsel", read_value_out, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    cfg_read(4'hC, v);
    check("reset_status", v, 32'd0);
    check("ready_follows_sel", 32'(ready_out), 32'd0);

    // Zero-wait three-word copy.
    setup(32'h100, 32'h200, 32'd3);
    base = wr_count;
    cfg_write(4'hC, 32'h1, 4'h1);
    check("t1_read_at_n1", 32'(m_read_out), 32'd1);
    check("t1_first_addr", m_address_out, 32'h100);
    wait_not_busy(cycles);
    check("t1_done_latency", 32'(cycles), 32'd6);
    cfg_read(4'hC, v); check("t1_status", v, 32'h2);
    check("t1_write_count", 32'(wr_count - base), 32'd3);
    check("t1_w0_addr", wlog_addr[base],   32'h200);
    check("t1_w0_data", wlog_data[base],   32'hA);
    check("t1_w1_data", wlog_data[base+1], 32'hB);
    check("t1_w2_addr", wlog_addr[base+2], 32'h208);
    check("t1_w2_data", wlog_data[base+2], 32'hC);
    cfg_read(4'h0, v); check("t1_src", v, 32'h10C);
    cfg_read(4'h4, v); check("t1_dst", v, 32'h20C);
    cfg_read(4'h8, v); check("t1_len", v, 32'd0);

    // Same copy with two wait cycles per access.
    waits = 2;
    setup(32'h100, 32'h200, 32'd3);
    base = wr_count; base_wait = wait_cycles; base_stab = stab_err;
    cfg_write(4'hC, 32'h1, 4'h1);
    wait_not_busy(cycles);
    check("t2_done_latency", 32'(cycles), 32'd18);
    check("t2_wait_cycles", 32'(wait_cycles - base_wait), 32'd12);
    check("t2_req_stable", 32'(stab_err - base_stab), 32'd0);
    check("t2_write_count", 32'(wr_count - base), 32'd3);
    check("t2_w1_addr", wlog_addr[base+1], 32'h204);
    check("t2_w1_data", wlog_data[base+1], 32'hB);
    check("t2_w2_data", wlog_data[base+2], 32'hC);
    waits = 0;

    // Read fault on the second source word.
    setup(32'h100, 32'h300, 32'd4);
    fault_en = 1'b1; fault_addr = 32'h104;
    base = wr_count;
    cfg_write(4'hC, 32'h1, 4'h1);
    wait_not_busy(cycles);
    fault_en = 1'b0;
    cfg_read(4'hC, v); check("t4_status", v, 32'h4);
    cfg_read(4'h0, v); check("t4_src", v, 32'h104);
    cfg_read(4'h4, v); check("t4_dst", v, 32'h304);
    cfg_read(4'h8, v); check("t4_len", v, 32'd3);
    check("t4_write_count", 32'(wr_count - base), 32'd1);

    // Abort during the second read; SRC write while busy must be ignored.
    setup(32'h100, 32'h400, 32'd5);
    base = wr_count;
    cfg_write(4'hC, 32'h1, 4'h1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t5_in_rd2", {31'd0, m_read_out}, 32'd1);
    check("t5_rd2_addr", m_address_out, 32'h104);
    cfg_write(4'hC, 32'h2, 4'h1);
    cfg_write(4'h0, 32'hDEAD_0000, 4'hF);
    wait_not_busy(cycles);
    check("t5_write_count", 32'(wr_count - base), 32'd2);
    check("t5_w1_addr", wlog_addr[base+1], 32'h404);
    check("t5_w1_data", wlog_data[base+1], 32'hB);
    cfg_read(4'hC, v); check("t5_status", v, 32'h0);
    cfg_read(4'h8, v); check("t5_len", v, 32'd3);
    cfg_read(4'h0, v); check("t5_src", v, 32'h108);

    // Reset asserted while a write is outstanding.
    setup(32'h100, 32'h500, 32'd3);
    cfg_write(4'hC, 32'h1, 4'h1);
    @(posedge clk); #1;
    check("t6_in_wr", 32'(m_write_out), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t6_m_outs_async", 32'(|{m_read_out, m_write_out, m_address_out, m_write_mask_out, m_write_value_out}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    cfg_read(4'h0, v); check("t6_src", v, 32'd0);
    cfg_read(4'h4, v); check("t6_dst", v, 32'd0);
    cfg_read(4'h8, v); check("t6_len", v, 32'd0);
    cfg_read(4'hC, v); check("t6_status", v, 32'd0);

    // Start with LEN==0 completes immediately without bus traffic.
    base_req = req_cycles;
    cfg_write(4'hC, 32'h1, 4'h1);
    cfg_read(4'hC, v); check("t3_status", v, 32'h2);
    repeat (4) @(posedge clk);
    #1;
    check("t3_no_requests", 32'(req_cycles - base_req), 32'd0);

    // Byte-lane write with forced word alignment.
    cfg_write(4'h0, 32'h1234_5677, 4'b0011);
    cfg_read(4'h0, v); check("lane_src", v, 32'h0000_5674);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
